// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle for the sequential shift-and-add multiplier.
// The requester drives start and the operands; the multiplier returns product/busy/done.
interface shift_add_multiplier_if #(
    parameter int nBit = 16
);
    logic                start;
    logic [nBit-1:0]     multiplicand;
    logic [nBit-1:0]     multiplier;
    logic [2*nBit-1:0]   product;
    logic                busy;
    logic                done;

    modport master (
        output start, multiplicand, multiplier,
        input  product, busy, done
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output product, busy, done
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, one add/shift iteration per clock.
// Registers update on the falling edge of clk, matching the neighbouring divider.
module shift_add_multiplier #(
    parameter int nBit = 16
) (
    input  logic                   clk,
    input  logic                   clr,
    shift_add_multiplier_if.slave  bus
);
    localparam int CW = $clog2(nBit) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [nBit:0]       r_a;        // partial product high half, with carry bit
    logic [nBit-1:0]     r_q;        // multiplier bits, consumed LSB first
    logic [nBit-1:0]     r_m;
    logic [CW-1:0]       r_count;
    logic [2*nBit-1:0]   r_product;
    logic                r_busy;
    logic                r_done;
    logic [nBit:0]       w_sum;

    // Conditional add of the multiplicand; A+M always fits in nBit+1 bits.
    always_comb begin
        w_sum = r_a;
        if (r_q[0])
            w_sum = r_a + {1'b0, r_m};
    end

    // Control FSM and datapath; clr takes priority over any start request.
    always_ff @(negedge clk) begin
        if (clr) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_count   <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= '0;
                        r_q     <= bus.multiplier;
                        r_m     <= bus.multiplicand;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // {A,Q} <= {S,Q} >> 1, zero entering the top of A
                    r_a     <= {1'b0, w_sum[nBit:1]};
                    r_q     <= {w_sum[0], r_q[nBit-1:1]};
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(nBit - 1)) begin
                        // Final iteration: the shifted {A[nBit-1:0],Q} is the product
                        r_product <= {w_sum, r_q[nBit-1:1]};
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        // Back-to-back acceptance straight out of DONE
                        r_a     <= '0;
                        r_q     <= bus.multiplier;
                        r_m     <= bus.multiplicand;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.product = r_product;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (nBit=16): table vectors, random
// operands against plain integer multiplication, and hand-written timing sequences.
module tb_shift_add_multiplier;
    localparam int N = 16;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [2*N-1:0] last_prod = '0;   // model of the product register

    shift_add_multiplier_if #(.nBit(N)) bus ();

    shift_add_multiplier #(.nBit(N)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   m;
        logic [N-1:0]   q;
        logic [2*N-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    // Advance past the next active (falling) edge; inputs and samples happen here.
    task automatic edge_step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Full operation from an idle/done DUT: start edge E0, done exactly after E(N).
    task automatic run_op(input string name, input logic [N-1:0] m, input logic [N-1:0] q,
                          input logic [2*N-1:0] exp);
        bus.start = 1'b1; bus.multiplicand = m; bus.multiplier = q;
        edge_step();                                 // E0
        bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
        check({name, " busy after start"}, 64'(bus.busy), 64'd1);
        for (int k = 1; k <= N; k++) begin
            edge_step();
            if (k < N) begin
                if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.product !== last_prod) begin
                    check({name, " run-phase busy/done/hold"},
                          {30'd0, bus.busy, bus.done, bus.product},
                          {30'd0, 1'b1, 1'b0, last_prod});
                end
            end
        end
        check({name, " done at E16"}, 64'(bus.done), 64'd1);
        check({name, " busy low at done"}, 64'(bus.busy), 64'd0);
        check({name, " product"}, 64'(bus.product), 64'(exp));
        last_prod = exp;
        edge_step();                                 // E(N+1)
        check({name, " done pulse ends"}, 64'(bus.done), 64'd0);
        check({name, " product holds"}, 64'(bus.product), 64'(last_prod));
    endtask

    initial begin
        vecs[0] = '{16'd3,      16'd5,      32'h0000_000F};
        vecs[1] = '{16'hFFFF,   16'hFFFF,   32'hFFFE_0001};
        vecs[2] = '{16'h0000,   16'h1234,   32'h0000_0000};
        vecs[3] = '{16'h8000,   16'h0002,   32'h0001_0000};
        vecs[4] = '{16'h0001,   16'hFFFF,   32'h0000_FFFF};
        vecs[5] = '{16'hFFFF,   16'h0000,   32'h0000_0000};
        vecs[6] = '{16'h8000,   16'h8000,   32'h4000_0000};
        vecs[7] = '{16'h1234,   16'h5678,   32'h0626_0060};

        bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;

        // Reset with start held high: nothing may start.
        clr = 1'b1; bus.start = 1'b1; bus.multiplicand = 16'd3; bus.multiplier = 16'd5;
        for (int i = 0; i < 2; i++) begin
            edge_step();
            check("reset product", 64'(bus.product), 64'd0);
            check("reset busy",    64'(bus.busy),    64'd0);
            check("reset done",    64'(bus.done),    64'd0);
        end
        clr = 1'b0; bus.start = 1'b0;
        edge_step();
        check("idle after reset busy", 64'(bus.busy), 64'd0);

        // Table vectors
        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].q, vecs[i].exp);

        // Random operands vs. integer multiply, with random idle gaps
        for (int i = 0; i < 20; i++) begin
            logic [N-1:0] m, q;
            logic [2*N-1:0] e;
            m = N'($urandom);
            q = N'($urandom);
            e = (2*N)'(m) * (2*N)'(q);
            run_op($sformatf("rand%0d", i), m, q, e);
            for (int g = $urandom_range(0, 2); g > 0; g--) edge_step();
        end

        // Start during RUN is ignored; old product holds until completion.
        bus.start = 1'b1; bus.multiplicand = 16'd7; bus.multiplier = 16'd9;
        edge_step();                                 // E0
        bus.start = 1'b0;
        for (int k = 1; k <= 4; k++) edge_step();    // E1..E4
        bus.start = 1'b1; bus.multiplicand = 16'd1; bus.multiplier = 16'd1;
        edge_step();                                 // E5
        bus.start = 1'b0;
        check("ignored start busy", 64'(bus.busy), 64'd1);
        for (int k = 6; k <= 15; k++) edge_step();
        check("ignored start hold product", 64'(bus.product), 64'(last_prod));
        check("ignored start no early done", 64'(bus.done), 64'd0);
        edge_step();                                 // E16
        check("ignored start done", 64'(bus.done), 64'd1);
        check("ignored start product", 64'(bus.product), 64'd63);
        last_prod = 32'd63;
        edge_step();
        check("ignored start idle", 64'(bus.busy), 64'd0);

        // Back-to-back with start held continuously
        bus.start = 1'b1; bus.multiplicand = 16'd6; bus.multiplier = 16'd7;
        edge_step();                                 // E0
        bus.multiplicand = 16'h00FF; bus.multiplier = 16'h0101;
        for (int k = 1; k <= 16; k++) edge_step();
        check("b2b first done", 64'(bus.done), 64'd1);
        check("b2b first product", 64'(bus.product), 64'd42);
        edge_step();                                 // E17: second accepted
        check("b2b second busy", 64'(bus.busy), 64'd1);
        check("b2b done falls", 64'(bus.done), 64'd0);
        for (int k = 18; k <= 32; k++) edge_step();
        check("b2b hold during second", 64'(bus.product), 64'd42);
        check("b2b no early done", 64'(bus.done), 64'd0);
        edge_step();                                 // E33
        bus.start = 1'b0;
        check("b2b second done", 64'(bus.done), 64'd1);
        check("b2b second product", 64'(bus.product), 64'h0000_FFFF);
        edge_step();
        check("b2b final done low", 64'(bus.done), 64'd0);
        check("b2b final busy low", 64'(bus.busy), 64'd0);

        // clr mid-RUN aborts; new start on the next edge works.
        bus.start = 1'b1; bus.multiplicand = 16'h1234; bus.multiplier = 16'h5678;
        edge_step();                                 // E0
        bus.start = 1'b0;
        for (int k = 1; k <= 7; k++) edge_step();
        clr = 1'b1;
        edge_step();                                 // E8
        clr = 1'b0;
        check("abort product", 64'(bus.product), 64'd0);
        check("abort busy",    64'(bus.busy),    64'd0);
        check("abort done",    64'(bus.done),    64'd0);
        bus.start = 1'b1; bus.multiplicand = 16'd2; bus.multiplier = 16'd3;
        edge_step();                                 // E9
        bus.start = 1'b0;
        check("restart busy", 64'(bus.busy), 64'd1);
        for (int k = 10; k <= 24; k++) begin
            edge_step();
            if (bus.done !== 1'b0) check("restart early done", 64'(bus.done), 64'd0);
        end
        edge_step();                                 // E25
        check("restart done", 64'(bus.done), 64'd1);
        check("restart product", 64'(bus.product), 64'd6);
        edge_step();
        check("restart done low", 64'(bus.done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned shift-and-add multiplier: the multiply-side counterpart of the team's shift-and-subtract divider, built on the same shift-register datapath style. It accepts two nBit operands on a start pulse, runs one add/shift iteration per clock, and presents a 2·nBit product with a one-cycle done pulse. It sits beside the divider in the arithmetic unit and shares its clocking and clear scheme.

## Interface
- nBit, 16, operand width; legal range 2..32.
- clk  input  1  clock; all registers update on the falling edge.
- clr  input  1  synchronous, active-high reset; sampled on the falling edge of clk.
- start  input  1  request; sampled only in IDLE or DONE.
- multiplicand  input  nBit  unsigned operand M; captured on accepted start.
- multiplier  input  nBit  unsigned operand Q; captured on accepted start.
- product  output  2·nBit  registered result; holds until the next completion.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse while in DONE.

## Operation
- Internal registers: A (nBit+1, includes carry), Q (nBit), M (nBit), count (clog2(nBit)+1 bits), state.
- States: IDLE, RUN, DONE.
- IDLE: if start=1, then A←0, Q←multiplier, M←multiplicand, count←0, state→RUN. Otherwise hold.
- RUN, each edge: S = Q[0] ? A + {0,M} : A (nBit+1-bit add, no overflow possible); {A,Q} ← {S,Q} >> 1 (zero shifted into A MSB); count++.
- RUN, on the edge where count reaches nBit-1 (the nBit-th iteration): the shifted {A[nBit-1:0],Q} is written to product; done←1; busy←0; state→DONE.
- DONE (one cycle): done=1. If start=1, a new operation is accepted exactly as in IDLE (back-to-back); otherwise state→IDLE. done falls on the next edge in either case.
- start in RUN is ignored; there is no queueing.
- Operand inputs are don't-care after capture.
- Arithmetic is unsigned; the result is exact, with no truncation.

## Timing
- Reset values (clr=1 at an edge): state=IDLE, product=0, busy=0, done=0, A=Q=M=count=0. clr overrides every other input.
- Edge E0: start accepted; busy=1 after E0.
- Edges E1..E(nBit): iterations. After E(nBit): product valid, done=1, busy=0.
- After E(nBit+1): done=0. Latency from start edge to done is nBit edges; throughput is one result per nBit+1 edges (back-to-back).
- clr mid-RUN aborts the operation: no done pulse, product returns to 0, and start is accepted from the following edge.
- clr and start on the same edge: clr wins and start is dropped.
- product changes only at the completion edge or on clr. It does not change during a subsequent RUN.

## Test plan
- Reset: assert clr for 2 edges with start=1 -> product=0, busy=0, done=0 throughout, with no operation started.
- Basic (nBit=16): M=3, Q=5, start at E0 -> busy high E0..E16, product=0x0000000F and done=1 after E16 only, done=0 after E17.
- Extremes: M=0xFFFF, Q=0xFFFF -> product=0xFFFE0001. M=0, Q=0x1234 -> 0. M=0x8000, Q=2 -> 0x00010000.
- Start during RUN: M=7, Q=9, then pulse start with M=1, Q=1 at E5 -> result 63 at E16. The second request is ignored, and the prior product holds before completion.
- Back-to-back: start held high continuously with 6×7 then 0x00FF×0x0101 -> 42 with done after E16, second op accepted at E17, 0x0000FFFF with done after E33.
- Mid-operation clr: M=0x1234, Q=0x5678, clr at E8 -> no done pulse, product=0, busy=0. A new start at E9 for 2×3 -> 6 after E25.
